// File: rtl/micro_sequencer.sv
// Microprogram sequencer for the multi-cycle MIPS datapath.
// Holds the micro-PC, chooses the next micro-address (sequential, dispatch 1,
// dispatch 2 or fetch restart), decodes the micro-PC into datapath controls,
// stalls on memory wait states and counts retired instructions.
module micro_sequencer #(
    parameter int UPC_W = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic [3:0]       dispatch1,
    input  logic             mem_ready,
    output logic [UPC_W-1:0] upc,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic             reg_write,
    output logic             reg_dst,
    output logic [1:0]       pc_source,
    output logic [1:0]       alu_op,
    output logic [1:0]       alu_src_b,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [UPC_W-1:0] {
        S_FETCH  = UPC_W'(0),
        S_DECODE = UPC_W'(1),
        S_MEMADR = UPC_W'(2),
        S_MEMRD  = UPC_W'(3),
        S_WB     = UPC_W'(4),
        S_MEMWR  = UPC_W'(5),
        S_RTYPE  = UPC_W'(6),
        S_RWB    = UPC_W'(7),
        S_BEQ    = UPC_W'(8),
        S_JMP    = UPC_W'(9)
    } state_t;

    state_t state;
    logic   stalled;
    logic   retire;

    // Internal dispatch table 2: loads and stores split after address calc.
    // Anything else recovers through fetch, same as an unsupported opcode.
    function automatic state_t dispatch2(input logic [5:0] o);
        case (o)
            6'd35:   return S_MEMRD;
            6'd43:   return S_MEMWR;
            default: return S_FETCH;
        endcase
    endfunction

    assign upc = state;

    // Memory states hold while the memory reports a wait state.
    assign stalled = ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR)) && !mem_ready;

    // An instruction retires on the edge that leaves any final micro-state.
    assign retire = !stalled && (state inside {S_WB, S_MEMWR, S_RWB, S_BEQ, S_JMP});

    // Micro-PC sequencing, retire pulse, sticky illegal flag and counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            instr_done  <= 1'b0;
            illegal_op  <= 1'b0;
            instr_count <= '0;
        end else begin
            instr_done <= retire;
            if (retire)
                instr_count <= instr_count + CNT_W'(1);
            if ((state == S_DECODE) && (dispatch1 == 4'd0) && (op != 6'd0))
                illegal_op <= 1'b1;
            if (!stalled) begin
                case (state)
                    S_FETCH:  state <= S_DECODE;
                    S_DECODE: state <= state_t'(UPC_W'(dispatch1));
                    S_MEMADR: state <= dispatch2(op);
                    S_MEMRD:  state <= S_WB;
                    S_RTYPE:  state <= S_RWB;
                    default:  state <= S_FETCH;
                endcase
            end
        end
    end

    // Moore decode of the micro-PC; fetch writes wait for memory and are
    // suppressed entirely while reset is asserted.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        pc_source     = 2'b00;
        alu_op        = 2'b00;
        alu_src_b     = 2'b00;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                alu_src_b = 2'b01;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_RTYPE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BEQ: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            default: ;
        endcase
        if (!rst_n) begin
            pc_write = 1'b0;
            ir_write = 1'b0;
        end
    end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Microprogram sequencer for the multi-cycle MIPS datapath. It holds the micro-PC (uPC) and selects the next micro-address from one of four sources: sequential increment, dispatch table 1 (opcode to micro-address, external input), internal dispatch table 2, or fetch restart.
- It decodes uPC into datapath control signals (Moore outputs), stalls on memory wait states, and counts retired instructions.
- It sits directly downstream of the dispatch-1 ROM and drives the datapath.

Parameters:
- UPC_W, 4, micro-PC width (micro-addresses 0..9 used).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- op  input  6  opcode field of the instruction register.
- dispatch1  input  4  micro-address from the dispatch-1 ROM: j→9, beq→8, R-type(0)→6, lw/sw→2, others→0.
- mem_ready  input  1  memory completion; low stalls micro-states 0, 3 and 5.
- upc  output  UPC_W  current micro-address.
- pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, alu_src_a, reg_write, reg_dst  output  1 each  datapath controls.
- pc_source, alu_op, alu_src_b  output  2 each  datapath selects.
- instr_done  output  1  one-cycle pulse when an instruction completes.
- illegal_op  output  1  registered sticky flag: decode state saw dispatch1==0 with op not 0.
- instr_count  output  CNT_W  retired instructions, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, rst_n=0): upc=0, instr_done=0, illegal_op=0, instr_count=0. Outputs then show state-0 decode; pc_write and ir_write are forced to 0 while rst_n=0. Reset mid-instruction abandons it with no count.
- Address control per state:
  - 0 sequential
  - 1 dispatch1
  - 2 dispatch2
  - 3 sequential
  - 4, 5, 7, 8, 9 fetch (next=0)
  - 6 sequential
- Dispatch2 (internal): op 35→3, op 43→5. Any other op→0, the same recovery path as illegal.
- Dispatch1 returning 0 (unsupported op) sends the next state to 0, so the instruction is dropped. illegal_op sets in state 1 only if op≠0; it clears only on reset.
- Stall: in states 0, 3 and 5 with mem_ready=0, upc holds, pc_write=0 and ir_write=0. mem_read/mem_write stay asserted. Advance on the first edge with mem_ready=1. Minimum latency with mem_ready=1:
  - R: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq: 3 cycles
  - j: 3 cycles
- instr_done: registered, high for one cycle after the edge leaving state 4, 5, 7, 8 or 9. instr_count increments on that same edge.
- Control decode (unlisted signals are 0):
  - S0: mem_read, ir_write (gated by mem_ready), pc_write (gated by mem_ready), alu_src_b=01, alu_op=00, pc_source=00, i_or_d=0.
  - S1: alu_src_b=11, alu_op=00.
  - S2: alu_src_a, alu_src_b=10, alu_op=00.
  - S3: mem_read, i_or_d.
  - S4: reg_write, mem_to_reg, reg_dst=0.
  - S5: mem_write, i_or_d.
  - S6: alu_src_a, alu_src_b=00, alu_op=10.
  - S7: reg_write, reg_dst, mem_to_reg=0.
  - S8: alu_src_a, alu_src_b=00, alu_op=01, pc_write_cond, pc_source=01.
  - S9: pc_write, pc_source=10.
- upc values 10..15 (unreachable): all controls 0, next=0.

Test Plan:
- Reset then release with mem_ready=1, op=0, dispatch1=6 → upc sequence 0,1,6,7,0. instr_done pulses once, instr_count=1, reg_dst=1 in S7.
- op=35, dispatch1=2, mem_ready low for 3 cycles in S3 → upc 0,1,2,3,3,3,3,4,0. mem_read held high throughout the stall, reg_write only in S4.
- op=43, dispatch1=2 → upc 0,1,2,5,0. mem_write=1 only in S5, instr_count increments by 1.
- op=4 (dispatch1=8), then op=2 (dispatch1=9) → S8 has pc_write_cond=1 and pc_source=01. S9 has pc_write=1 and pc_source=10. Each instruction takes 3 cycles.
- op=63, dispatch1=0 → upc 0,1,0, illegal_op=1 and stays 1. instr_count is unchanged.
- Assert rst_n=0 asynchronously while in S3 → upc=0, instr_count=0, illegal_op=0 immediately without waiting for a clock edge. pc_write=0 and ir_write=0 while in reset.
